// File: rtl/capture_buf_ctrl.sv
// capture_buf_ctrl: frame sequencer for the single-port sample RAM.
// Arms once per frame, waits for a trigger, writes DEPTH ADC samples into
// the RAM, then streams them back out through a valid/ready port.
// Optional feature macro: TRIG_LEVEL_EN (rising level-crossing trigger).
module capture_buf_ctrl #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 10,
  parameter int DEPTH       = 2048,
  parameter int FRAME_TICKS = 500_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              auto_en,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
`ifdef TRIG_LEVEL_EN
  input  logic [DATA_W-1:0] trig_level,
`endif
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0] rd_idx,
  input  logic              rd_ready,
  output logic              frame_tick,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  localparam int CNT_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(FRAME_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_TRIG, CAPTURE, RD_ADDR, RD_DATA, RD_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  frame_cnt_q;
  logic [ADDR_W-1:0] wr_idx_q, wr_idx_d;
  logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
  logic              wr_pend_q, wr_pend_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;
  logic              trig;
`ifdef TRIG_LEVEL_EN
  logic [DATA_W-1:0] prev_q, prev_d;
  logic              prev_vld_q, prev_vld_d;
`endif

  // Trigger qualification for the current adc_valid cycle
  always_comb begin
`ifdef TRIG_LEVEL_EN
    trig = adc_valid && prev_vld_q && (prev_q < trig_level) && (adc_data >= trig_level);
`else
    trig = adc_valid;
`endif
  end

  // Free-running frame period counter; tick is suppressed while in reset
  always_ff @(posedge clk) begin
    if (rst || frame_cnt_q == LAST_CNT) frame_cnt_q <= '0;
    else                                frame_cnt_q <= frame_cnt_q + 1'b1;
  end

  // Next-state and register updates for the capture/readout sequence
  always_comb begin
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    wr_pend_d = 1'b0;
    wr_data_d = wr_data_q;
    rd_data_d = rd_data_q;
    done_d    = 1'b0;
    // A frame tick that lands while a capture/readout is in flight is lost.
    overrun_d = overrun_q | (frame_tick & busy);
`ifdef TRIG_LEVEL_EN
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef TRIG_LEVEL_EN
        prev_vld_d = 1'b0;
`endif
        if (start) begin
          state_d   = WAIT_TRIG;
          overrun_d = 1'b0;
        end else if (auto_en && frame_tick) begin
          state_d = WAIT_TRIG;
        end
      end
      WAIT_TRIG: begin
`ifdef TRIG_LEVEL_EN
        if (adc_valid) begin
          prev_d     = adc_data;
          prev_vld_d = 1'b1;
        end
`endif
        if (trig) begin
          state_d   = CAPTURE;
          wr_pend_d = 1'b1;
          wr_data_d = adc_data;
        end
      end
      CAPTURE: begin
        if (wr_pend_q) begin
          wr_idx_d = wr_idx_q + 1'b1;
          if (wr_idx_q == LAST_IDX) begin
            state_d  = RD_ADDR;
            wr_idx_d = '0;
            rd_idx_d = '0;
          end
        end
        // Stop accepting once DEPTH samples are registered (last one may be pending).
        if (adc_valid && !(wr_pend_q && wr_idx_q == LAST_IDX)) begin
          wr_pend_d = 1'b1;
          wr_data_d = adc_data;
        end
      end
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: begin
        rd_data_d = ram_rdata;
        state_d   = RD_HOLD;
      end
      RD_HOLD: begin
        if (rd_ready) begin
          if (rd_idx_q == LAST_IDX) begin
            done_d   = 1'b1;
            rd_idx_d = '0;
            state_d  = IDLE;
          end else begin
            rd_idx_d = rd_idx_q + 1'b1;
            state_d  = RD_ADDR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state registers (reset returns to an empty IDLE frame)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      wr_pend_q  <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef TRIG_LEVEL_EN
      prev_vld_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      wr_pend_q  <= wr_pend_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
`ifdef TRIG_LEVEL_EN
      prev_vld_q <= prev_vld_d;
`endif
    end
  end

  // Sample data registers; qualified by control flags, so no reset needed
  always_ff @(posedge clk) begin
    wr_data_q <= wr_data_d;
    rd_data_q <= rd_data_d;
`ifdef TRIG_LEVEL_EN
    prev_q    <= prev_d;
`endif
  end

  // Output decode; data outputs are forced to zero when not qualified
  always_comb begin
    frame_tick = !rst && (frame_cnt_q == '0);
    busy       = (state_q != IDLE);
    ram_we     = wr_pend_q;
    ram_addr   = (state_q == RD_ADDR || state_q == RD_DATA || state_q == RD_HOLD) ?
                 rd_idx_q : wr_idx_q;
    ram_wdata  = wr_pend_q ? wr_data_q : '0;
    rd_valid   = (state_q == RD_HOLD);
    rd_data    = (state_q == RD_HOLD) ? rd_data_q : '0;
    rd_idx     = rd_idx_q;
    done       = done_q;
    overrun    = overrun_q;
  end

endmodule

// File: tb/tb_capture_buf_ctrl.sv
// Bench for capture_buf_ctrl: frame-level reference model plus behavioural RAM.
module tb_capture_buf_ctrl;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 10;
  localparam int DEPTH  = 16;
  localparam int FT     = 100;

  logic clk = 1'b0;
  logic rst, start, auto_en, adc_valid, rd_ready;
  logic [DATA_W-1:0] adc_data, ram_rdata, ram_wdata, rd_data;
  logic [ADDR_W-1:0] ram_addr, rd_idx;
  logic ram_we, rd_valid, frame_tick, busy, done, overrun;
`ifdef TRIG_LEVEL_EN
  logic [DATA_W-1:0] trig_level;
`endif

  always #5 clk = ~clk;

  capture_buf_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .FRAME_TICKS(FT)) dut (
    .clk(clk), .rst(rst), .start(start), .auto_en(auto_en),
    .adc_valid(adc_valid), .adc_data(adc_data),
`ifdef TRIG_LEVEL_EN
    .trig_level(trig_level),
`endif
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_idx(rd_idx), .rd_ready(rd_ready),
    .frame_tick(frame_tick), .busy(busy), .done(done), .overrun(overrun)
  );

  // Behavioural single-port RAM with one-cycle read latency
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (ram_we === 1'b1) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base = 0;
  int phase = 0;            // 0 idle, 1 collecting/writing, 2 reading out
  int n_wr = 0, n_rd = 0, rv_start = 0, done_at = -1;
  bit ovr = 1'b0;
  logic [DATA_W-1:0] sq[$];
  int sc[$];
  logic [DATA_W-1:0] m_prev = '0;
  bit m_prev_vld = 1'b0;
  int ramp_v = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // One clock: compare outputs against the model mid-cycle, advance the model,
  // then move inputs just after the next rising edge.
  task automatic step();
    bit tick, ewe, erv;
    @(negedge clk);
    tick = !rst && (((cyc - base) % FT) == 0);
    ewe  = (phase == 1) && (n_wr < sq.size()) && (sc[n_wr] + 1 == cyc);
    erv  = (phase == 2) && (cyc >= rv_start);
    chk("frame_tick", 32'(frame_tick), 32'(tick));
    chk("busy", 32'(busy), 32'(phase != 0));
    chk("ram_we", 32'(ram_we), 32'(ewe));
    if (ewe) begin
      chk("ram_addr", 32'(ram_addr), n_wr);
      chk("ram_wdata", 32'(ram_wdata), 32'(sq[n_wr]));
    end
    chk("rd_valid", 32'(rd_valid), 32'(erv));
    if (erv) begin
      chk("rd_data", 32'(rd_data), 32'(sq[n_rd]));
      chk("rd_idx", 32'(rd_idx), n_rd);
    end
    chk("done", 32'(done), 32'(cyc == done_at));
    chk("overrun", 32'(overrun), 32'(ovr));
    if (rst) begin
      phase = 0; ovr = 1'b0; n_wr = 0; n_rd = 0; done_at = -1;
      sq.delete(); sc.delete(); m_prev_vld = 1'b0; base = cyc + 1;
    end else begin
      if (tick && phase != 0) ovr = 1'b1;
      case (phase)
        0: if (start || (auto_en && tick)) begin
          if (start) ovr = 1'b0;
          phase = 1; n_wr = 0; n_rd = 0; sq.delete(); sc.delete(); m_prev_vld = 1'b0;
        end
        1: begin
          if (ewe) begin
            n_wr++;
            if (n_wr == DEPTH) begin phase = 2; rv_start = cyc + 3; end
          end
          if (adc_valid && sq.size() < DEPTH) begin
`ifdef TRIG_LEVEL_EN
            if (sq.size() > 0 || (m_prev_vld && m_prev < trig_level && adc_data >= trig_level)) begin
              sq.push_back(adc_data); sc.push_back(cyc);
            end
            m_prev = adc_data; m_prev_vld = 1'b1;
`else
            sq.push_back(adc_data); sc.push_back(cyc);
`endif
          end
        end
        default: if (erv && rd_ready) begin
          n_rd++;
          if (n_rd == DEPTH) begin phase = 0; done_at = cyc + 1; end
          else rv_start = cyc + 3;
        end
      endcase
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  // One frame: vdiv>0 gives a valid every vdiv clocks, 0 gives random valids.
  task automatic run_frame(input bit use_auto, input int vdiv, input bit ramp, input int rpct,
                           input int stall_at, input int gap_at, input int rst_at, input bit poke);
    int b, k, stall, gap;
    bit armed, gap_used, did_rst, did_poke;
    k = 0; stall = 0; gap = 0; armed = 0; gap_used = 0; did_rst = 0; did_poke = 0;
    if (use_auto) auto_en = 1'b1; else start = 1'b1;
    for (b = 0; b < 3000; b++) begin
      if (gap_at >= 0 && !gap_used && sq.size() == gap_at) begin gap = 50; gap_used = 1; end
      if (gap > 0) begin adc_valid = 1'b0; gap--; end
      else if (vdiv > 0) adc_valid = ((k % vdiv) == 0);
      else adc_valid = ($urandom_range(0, 2) == 0);
      k++;
      if (ramp) begin adc_data = DATA_W'(ramp_v); ramp_v++; end
      else adc_data = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
      if (n_rd == stall_at && stall < 10 && phase == 2) begin
        rd_ready = 1'b0;
        if (cyc >= rv_start) stall++;
      end else rd_ready = ($urandom_range(0, 99) < rpct);
      if (rst_at >= 0 && !did_rst && phase == 1 && n_wr == rst_at) begin rst = 1'b1; did_rst = 1; end
      if (poke && !did_poke && phase == 1 && n_wr == 3) begin start = 1'b1; did_poke = 1; end
      step();
      start = 1'b0; rst = 1'b0;
      if (phase != 0) armed = 1;
      if (armed && phase == 0) break;
    end
    auto_en = 1'b0; adc_valid = 1'b0; rd_ready = 1'b0;
    chk("frame_budget", 32'(b < 3000), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; auto_en = 1'b0; adc_valid = 1'b0;
    adc_data = '0; rd_ready = 1'b0;
`ifdef TRIG_LEVEL_EN
    trig_level = DATA_W'(512);
`endif
    repeat (3) step();
    rst = 1'b0;
    repeat (2) step();
    // ramp data, valid every clk, consumer always ready
    run_frame(1'b0, 1, 1'b1, 100, -1, -1, -1, 1'b0);
    repeat (3) step();
    // random valids and backpressure, 10-clk stall at index 5, start while busy
    run_frame(1'b0, 0, 1'b0, 60, 5, -1, -1, 1'b1);
    repeat (3) step();
    // auto re-arm with sparse valids: frame outlasts the period -> overrun
    run_frame(1'b1, 4, 1'b0, 100, -1, -1, -1, 1'b0);
    repeat (3) step();
    // start clears overrun; 50-clk valid gap mid-capture
    run_frame(1'b0, 0, 1'b0, 80, -1, 8, -1, 1'b0);
    repeat (3) step();
    // reset mid-capture, then a clean frame from index 0
    run_frame(1'b0, 1, 1'b0, 100, -1, -1, 7, 1'b0);
    repeat (3) step();
    run_frame(1'b0, 0, 1'b0, 50, -1, -1, -1, 1'b0);
    repeat (5) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
